// File: rtl/dp_job_sequencer_pkg.sv
// Shared constants and FSM state encoding for the DP job sequencer.
package dp_job_sequencer_pkg;

  localparam int unsigned DP_N          = 64;
  localparam int unsigned DP_LOG_N      = 6;
  localparam int unsigned DP_BP_WIDTH   = 2;
  localparam int unsigned DP_ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_S   = 3'd1,
    ST_STREAM_T = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_WAIT_TB  = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_e;

endpackage

// File: rtl/dp_job_sequencer_skid.sv
// One-entry skid buffer: passes data straight through, and parks a word
// that is presented while stall is high until stall drops.
module dp_skid_reg #(
  parameter int unsigned BP_WIDTH = 2
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                in_valid,
  input  logic [BP_WIDTH-1:0] in_data,
  input  logic                stall,
  output logic                out_valid,
  output logic [BP_WIDTH-1:0] out_data
);

  logic                full_q;
  logic [BP_WIDTH-1:0] data_q;

  // Hold the presented word while it is stalled; otherwise track the input.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= stall && out_valid;
      if (!full_q) begin
        data_q <= in_data;
      end
    end
  end

  // Buffered word has priority over the live input.
  always_comb begin
    out_valid = full_q || in_valid;
    out_data  = full_q ? data_q : in_data;
  end

endmodule

// File: rtl/dp_job_sequencer.sv
// Job-level controller for the ping-pong DP systolic wrapper: loads the
// query into the PEs, streams the reference, then closes the job with a
// new_seq pulse once traceback is free.
module dp_job_sequencer
  import dp_job_sequencer_pkg::*;
#(
  parameter int unsigned N          = DP_N,
  parameter int unsigned LOG_N      = DP_LOG_N,
  parameter int unsigned BP_WIDTH   = DP_BP_WIDTH,
  parameter int unsigned ADDR_WIDTH = DP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [LOG_N:0]        job_qlen,
  input  logic [ADDR_WIDTH:0]   job_rlen,
  output logic                  job_err,
  output logic                  rd_en,
  output logic                  rd_sel,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BP_WIDTH-1:0]   rd_data,
  output logic [BP_WIDTH-1:0]   S,
  output logic                  s_update,
  output logic [BP_WIDTH-1:0]   T,
  output logic                  valid,
  input  logic                  busy,
  output logic [LOG_N-1:0]      PE_end,
  output logic                  new_seq,
  input  logic                  tb_busy,
  output logic                  job_done
);

  localparam int unsigned QW = LOG_N + 1;
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [QW-1:0] QLEN_MAX = QW'(N);
  localparam logic [CW-1:0] RLEN_MAX = CW'(2 ** ADDR_WIDTH);

  seq_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [QW-1:0]      qlen_q, qlen_d;
  logic [CW-1:0]      rlen_q, rlen_d;
  logic [LOG_N-1:0]   pe_end_q, pe_end_d;
  logic               job_err_q, job_err_d;
  logic               rd_s_q, rd_t_q;
  logic               job_legal;

  logic               t_valid;
  logic [BP_WIDTH-1:0] t_data;
  logic               skid_full;

  dp_skid_reg #(
    .BP_WIDTH(BP_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset_i  (reset_i),
    .in_valid (rd_t_q),
    .in_data  (rd_data),
    .stall    (busy),
    .out_valid(t_valid),
    .out_data (t_data)
  );

  // A read is never issued while the skid holds a word, so whenever the skid
  // is presenting without a live return, the presented word is the parked one.
  assign skid_full = t_valid && !rd_t_q;

  // State, counters, and the one-cycle read-return tags.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      qlen_q    <= '0;
      rlen_q    <= '0;
      pe_end_q  <= '0;
      job_err_q <= 1'b0;
      rd_s_q    <= 1'b0;
      rd_t_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qlen_q    <= qlen_d;
      rlen_q    <= rlen_d;
      pe_end_q  <= pe_end_d;
      job_err_q <= job_err_d;
      rd_s_q    <= rd_en && !rd_sel;
      rd_t_q    <= rd_en && rd_sel;
    end
  end

  // Next-state, counter update and read-port control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qlen_d    = qlen_q;
    rlen_d    = rlen_q;
    pe_end_d  = pe_end_q;
    job_err_d = 1'b0;
    rd_en     = 1'b0;
    rd_sel    = 1'b0;
    rd_addr   = '0;
    job_ready = 1'b0;
    new_seq   = 1'b0;
    job_done  = 1'b0;
    job_legal = (job_qlen != '0) && (job_qlen <= QLEN_MAX) &&
                (job_rlen != '0) && (job_rlen <= RLEN_MAX);

    case (state_q)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          if (job_legal) begin
            qlen_d   = job_qlen;
            rlen_d   = job_rlen;
            pe_end_d = LOG_N'(job_qlen - QW'(1));
            cnt_d    = '0;
            state_d  = ST_LOAD_S;
          end else begin
            job_err_d = 1'b1;
          end
        end
      end
      ST_LOAD_S: begin
        if (cnt_q == CW'(qlen_q)) begin
          cnt_d   = '0;
          state_d = ST_STREAM_T;
        end else begin
          rd_en   = 1'b1;
          rd_addr = cnt_q[ADDR_WIDTH-1:0];
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_STREAM_T: begin
        if (!busy && !skid_full) begin
          rd_en   = 1'b1;
          rd_sel  = 1'b1;
          rd_addr = cnt_q[ADDR_WIDTH-1:0];
          if (cnt_q == rlen_q - CW'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Exactly one word is outstanding here; leave once the DP takes it.
        if (t_valid && !busy) begin
          state_d = ST_WAIT_TB;
        end
      end
      ST_WAIT_TB: begin
        if (!tb_busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        new_seq  = 1'b1;
        job_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // DP-facing data paths, forced to zero when not qualified.
  always_comb begin
    s_update = rd_s_q;
    S        = rd_s_q ? rd_data : '0;
    valid    = t_valid;
    T        = t_valid ? t_data : '0;
    PE_end   = pe_end_q;
    job_err  = job_err_q;
  end

endmodule

// File: tb/tb_dp_job_sequencer.sv
// Directed self-checking bench for dp_job_sequencer.
module tb_dp_job_sequencer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        job_valid;
  logic        job_ready;
  logic [6:0]  job_qlen;
  logic [10:0] job_rlen;
  logic        job_err;
  logic        rd_en;
  logic        rd_sel;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_data;
  logic [1:0]  S;
  logic        s_update;
  logic [1:0]  T;
  logic        valid;
  logic        busy;
  logic [5:0]  PE_end;
  logic        new_seq;
  logic        tb_busy;
  logic        job_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [1:0] qmem [0:1023];
  logic [1:0] rmem [0:1023];
  logic [1:0] s_log [0:4095];
  logic [1:0] t_log [0:4095];
  int s_n = 0, t_n = 0, stall_n = 0, rd_n = 0, ns_n = 0, ns_cyc = 0;
  int err_n = 0, overlap_n = 0, notready_n = 0, jd_mis_n = 0;
  logic [9:0] last_taddr = '0;

  dp_job_sequencer #(
    .N(64),
    .LOG_N(6),
    .BP_WIDTH(2),
    .ADDR_WIDTH(10)
  ) dut (
    .clk      (clk),
    .reset_i  (reset_i),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_qlen (job_qlen),
    .job_rlen (job_rlen),
    .job_err  (job_err),
    .rd_en    (rd_en),
    .rd_sel   (rd_sel),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .S        (S),
    .s_update (s_update),
    .T        (T),
    .valid    (valid),
    .busy     (busy),
    .PE_end   (PE_end),
    .new_seq  (new_seq),
    .tb_busy  (tb_busy),
    .job_done (job_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sequence buffer: registered read, data one cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= rd_sel ? rmem[rd_addr] : qmem[rd_addr];

  function automatic logic [1:0] qpat(input int i);
    return 2'((i * 3 + 1) & 3);
  endfunction

  function automatic logic [1:0] rpat(input int i);
    return 2'((i + (i >> 2)) & 3);
  endfunction

  // Observe DP-side traffic mid-cycle.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (s_update && s_n < 4096) begin s_log[s_n] = S; s_n++; end
      if (valid && !busy && t_n < 4096) begin t_log[t_n] = T; t_n++; end
      if (valid && busy) stall_n++;
      if (rd_en) rd_n++;
      if (rd_en && rd_sel) last_taddr = rd_addr;
      if (new_seq) begin ns_n++; ns_cyc = cyc; end
      if (job_err) err_n++;
      if (s_update && valid) overlap_n++;
      if (!job_ready) notready_n++;
      if (job_done != new_seq) jd_mis_n++;
    end
  end

  // Call at a rising edge; returns 1ns after the accepting edge with acc = that cycle.
  task automatic submit(input int q, input int r, output int acc);
    #1;
    job_valid = 1'b1;
    job_qlen  = 7'(q);
    job_rlen  = 11'(r);
    @(posedge clk);
    #1;
    acc       = cyc;
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (ns_n != base) break;
    end
    n_checks++;
    if (ns_n == base) $display("FAIL wait_done: new_seq count %0d, required >%0d within %0d cycles", ns_n, base, limit);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [26:0] outv;
    reset_i = 1'b1; job_valid = 1'b0; job_qlen = '0; job_rlen = '0;
    busy = 1'b0; tb_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outv = {valid, rd_en, rd_sel, s_update, new_seq, job_done, job_err, rd_addr, S, T, PE_end};
    n_checks++;
    if (outv !== 27'd0) $display("FAIL reset_outputs: got %h expected 0", outv); else n_pass++;
    n_checks++;
    if (job_ready !== 1'b1) $display("FAIL reset_job_ready: got %b expected 1", job_ready); else n_pass++;
    #2 reset_i = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_basic();
    int acc, sb, tb, nb, bad, ob, jb;
    sb = s_n; tb = t_n; nb = ns_n; ob = overlap_n; jb = jd_mis_n;
    @(posedge clk);
    submit(4, 8, acc);
    n_checks++;
    if (PE_end !== 6'd3) $display("FAIL basic_pe_end: got %0d expected 3", PE_end); else n_pass++;
    n_checks++;
    if (job_ready !== 1'b0) $display("FAIL basic_busy_ready: got %b expected 0", job_ready); else n_pass++;
    wait_done(nb, 100);
    repeat (2) @(posedge clk);
    bad = 0;
    for (int k = 0; k < 4; k++) if (s_log[sb + k] !== qpat(k)) bad++;
    n_checks++;
    if (s_n - sb != 4 || bad != 0) $display("FAIL basic_s_seq: got %0d words (%0d wrong) expected 4 (0 wrong)", s_n - sb, bad); else n_pass++;
    bad = 0;
    for (int k = 0; k < 8; k++) if (t_log[tb + k] !== rpat(k)) bad++;
    n_checks++;
    if (t_n - tb != 8 || bad != 0) $display("FAIL basic_t_seq: got %0d words (%0d wrong) expected 8 (0 wrong)", t_n - tb, bad); else n_pass++;
    n_checks++;
    if (ns_cyc - acc != 15) $display("FAIL basic_latency: got %0d expected 15", ns_cyc - acc); else n_pass++;
    n_checks++;
    if (ns_n - nb != 1) $display("FAIL basic_new_seq_count: got %0d expected 1", ns_n - nb); else n_pass++;
    n_checks++;
    if (overlap_n - ob != 0 || jd_mis_n - jb != 0)
      $display("FAIL basic_exclusive: overlap %0d done_mismatch %0d expected 0 0", overlap_n - ob, jd_mis_n - jb);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, nb, tb, bad, first_ns;
    nb = ns_n;
    @(posedge clk);
    submit(2, 2, acc1);
    wait_done(nb, 100);
    first_ns = ns_cyc;
    nb = ns_n; tb = t_n;
    submit(3, 5, acc2);
    n_checks++;
    if (acc2 - first_ns != 2) $display("FAIL b2b_accept: got accept %0d cycles after done expected 2", acc2 - first_ns); else n_pass++;
    wait_done(nb, 100);
    n_checks++;
    if (ns_cyc - acc2 != 11) $display("FAIL b2b_latency: got %0d expected 11", ns_cyc - acc2); else n_pass++;
    bad = 0;
    for (int k = 0; k < 5; k++) if (t_log[tb + k] !== rpat(k)) bad++;
    n_checks++;
    if (t_n - tb != 5 || bad != 0) $display("FAIL b2b_t_seq: got %0d words (%0d wrong) expected 5 (0 wrong)", t_n - tb, bad); else n_pass++;
  endtask

  task automatic test_busy_skid();
    int acc, nb, tb, st, bad;
    nb = ns_n; tb = t_n; st = stall_n;
    @(posedge clk);
    submit(4, 8, acc);
    repeat (8) @(posedge clk);
    #1 busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 busy = 1'b0;
    wait_done(nb, 100);
    bad = 0;
    for (int k = 0; k < 8; k++) if (t_log[tb + k] !== rpat(k)) bad++;
    n_checks++;
    if (t_n - tb != 8 || bad != 0) $display("FAIL skid_t_seq: got %0d words (%0d wrong) expected 8 (0 wrong)", t_n - tb, bad); else n_pass++;
    n_checks++;
    if (stall_n - st != 3) $display("FAIL skid_stall_cycles: got %0d expected 3", stall_n - st); else n_pass++;
    n_checks++;
    if (ns_cyc - acc != 19) $display("FAIL skid_latency: got %0d expected 19", ns_cyc - acc); else n_pass++;
  endtask

  task automatic test_tb_busy();
    int acc, nb, nr, fall;
    nb = ns_n;
    tb_busy = 1'b1;
    @(posedge clk);
    submit(3, 4, acc);
    nr = notready_n;
    repeat (20) @(posedge clk);
    n_checks++;
    if (ns_n - nb != 0) $display("FAIL tbb_held: got %0d new_seq expected 0", ns_n - nb); else n_pass++;
    n_checks++;
    if (notready_n - nr != 20) $display("FAIL tbb_not_ready: got %0d not-ready cycles expected 20", notready_n - nr); else n_pass++;
    #1;
    fall = cyc;
    tb_busy = 1'b0;
    wait_done(nb, 20);
    n_checks++;
    if (ns_cyc - fall != 1) $display("FAIL tbb_release: got new_seq %0d cycles after fall expected 1", ns_cyc - fall); else n_pass++;
  endtask

  task automatic test_illegal();
    int acc, eb, rb, sb, nb, nr;
    eb = err_n; rb = rd_n; sb = s_n; nb = ns_n; nr = notready_n;
    @(posedge clk);
    submit(0, 5, acc);
    n_checks++;
    if (job_err !== 1'b1) $display("FAIL illegal_q0_err: got %b expected 1", job_err); else n_pass++;
    @(posedge clk);
    submit(65, 5, acc);
    n_checks++;
    if (job_err !== 1'b1) $display("FAIL illegal_q65_err: got %b expected 1", job_err); else n_pass++;
    repeat (5) @(posedge clk);
    n_checks++;
    if (err_n - eb != 2) $display("FAIL illegal_err_count: got %0d expected 2", err_n - eb); else n_pass++;
    n_checks++;
    if (rd_n - rb != 0 || s_n - sb != 0 || ns_n - nb != 0)
      $display("FAIL illegal_no_activity: rd %0d s %0d ns %0d expected 0 0 0", rd_n - rb, s_n - sb, ns_n - nb);
    else n_pass++;
    n_checks++;
    if (notready_n - nr != 0) $display("FAIL illegal_ready: got %0d not-ready cycles expected 0", notready_n - nr); else n_pass++;
  endtask

  task automatic test_max_job();
    int acc, nb, sb, tb, bad, ob;
    nb = ns_n; sb = s_n; tb = t_n; ob = overlap_n;
    @(posedge clk);
    submit(64, 1024, acc);
    n_checks++;
    if (PE_end !== 6'd63) $display("FAIL max_pe_end: got %0d expected 63", PE_end); else n_pass++;
    wait_done(nb, 3000);
    bad = 0;
    for (int k = 0; k < 64; k++) if (s_log[sb + k] !== qpat(k)) bad++;
    n_checks++;
    if (s_n - sb != 64 || bad != 0) $display("FAIL max_s_seq: got %0d words (%0d wrong) expected 64 (0 wrong)", s_n - sb, bad); else n_pass++;
    bad = 0;
    for (int k = 0; k < 1024; k++) if (t_log[tb + k] !== rpat(k)) bad++;
    n_checks++;
    if (t_n - tb != 1024 || bad != 0) $display("FAIL max_t_seq: got %0d words (%0d wrong) expected 1024 (0 wrong)", t_n - tb, bad); else n_pass++;
    n_checks++;
    if (last_taddr !== 10'h3FF) $display("FAIL max_last_addr: got %h expected 3ff", last_taddr); else n_pass++;
    n_checks++;
    if (ns_cyc - acc != 1091) $display("FAIL max_latency: got %0d expected 1091", ns_cyc - acc); else n_pass++;
    n_checks++;
    if (overlap_n - ob != 0) $display("FAIL max_overlap: got %0d expected 0", overlap_n - ob); else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    int acc, nb, sb, tb, bad;
    logic [26:0] outv;
    nb = ns_n;
    @(posedge clk);
    submit(4, 8, acc);
    repeat (8) @(posedge clk);
    #3 reset_i = 1'b1;
    #1;
    outv = {valid, rd_en, rd_sel, s_update, new_seq, job_done, job_err, rd_addr, S, T, PE_end};
    n_checks++;
    if (outv !== 27'd0) $display("FAIL midrst_outputs: got %h expected 0", outv); else n_pass++;
    repeat (2) @(posedge clk);
    #3 reset_i = 1'b0;
    repeat (10) @(posedge clk);
    n_checks++;
    if (ns_n - nb != 0) $display("FAIL midrst_no_new_seq: got %0d expected 0", ns_n - nb); else n_pass++;
    #1;
    n_checks++;
    if (job_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", job_ready); else n_pass++;
    nb = ns_n; sb = s_n; tb = t_n;
    @(posedge clk);
    submit(2, 3, acc);
    wait_done(nb, 100);
    bad = 0;
    for (int k = 0; k < 2; k++) if (s_log[sb + k] !== qpat(k)) bad++;
    for (int k = 0; k < 3; k++) if (t_log[tb + k] !== rpat(k)) bad++;
    n_checks++;
    if (s_n - sb != 2 || t_n - tb != 3 || bad != 0)
      $display("FAIL midrst_clean_job: got s %0d t %0d wrong %0d expected 2 3 0", s_n - sb, t_n - tb, bad);
    else n_pass++;
    n_checks++;
    if (ns_cyc - acc != 8) $display("FAIL midrst_latency: got %0d expected 8", ns_cyc - acc); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      qmem[i] = qpat(i);
      rmem[i] = rpat(i);
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_busy_skid();
    test_tb_busy();
    test_illegal();
    test_max_job();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
